cordic_arbiter: RTL and testbench

Round-robin scheduler that shares one `cordic` core among `N_REQ` requesters. It owns the core's `start`/`angle` inputs and sequences one rotation at a time. It returns each result `(out_x, out_y)` to the requester that issued the angle, and it enforces the start-hold and idle-gap rules the core requires between operations. It sits between the client blocks and the single instantiated `cordic` core.

---
 rtl/cordic_arbiter.sv | 148 ++++++++++++++
 tb/tb_cordic_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_arbiter.sv
// cordic_arbiter: round-robin sharing of one cordic core among N_REQ requesters; define CORDIC_ARB_TIMEOUT_EN to add a RUN watchdog
module cordic_arbiter #(
  parameter int N_REQ          = 4,
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_angle,
  output logic [N_REQ-1:0]       req_ack,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]       rsp_x,
  output logic [WIDTH-1:0]       rsp_y,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   cordic_start,
  output logic [WIDTH-1:0]       cordic_angle,
  input  logic                   cordic_done,
  input  logic [WIDTH-1:0]       cordic_x,
  input  logic [WIDTH-1:0]       cordic_y
);
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, RUN, RESP, GAP} state_t;
  state_t           state_q, state_d;
  logic [IW-1:0]    g_q, g_d, ptr_q, ptr_d, gnt;
  logic             found;
  logic [WIDTH-1:0] angle_sel, angle_q, angle_d, x_q, x_d, y_q, y_d;
  logic [N_REQ-1:0] ack_q, ack_d, valid_q, valid_d;
  logic             start_q, start_d, busy_q, busy_d;
  if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("cordic_arbiter: unsupported parameter set");
  end
  function automatic int wrap(input int v);
    return v >= N_REQ ? v - N_REQ : v;
  endfunction
  always_comb begin
    found = 1'b0;
    gnt = ptr_q;
    angle_sel = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap(int'(ptr_q) + k)]) begin
        found = 1'b1;
        gnt = IW'(wrap(int'(ptr_q) + k));
        angle_sel = req_angle[wrap(int'(ptr_q) + k) * WIDTH +: WIDTH];
      end
    end
  end
`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    ptr_d = ptr_q;
    angle_d = angle_q;
    start_d = start_q;
    x_d = x_q;
    y_d = y_q;
    ack_d = '0;
    valid_d = '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
    err_d = 1'b0;
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE: if (found) begin
        state_d = RUN;
        g_d = gnt;
        angle_d = angle_sel;
        start_d = 1'b1;
        ack_d[gnt] = 1'b1;
`ifdef CORDIC_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      RUN: if (cordic_done) begin
        state_d = RESP;
        start_d = 1'b0;
        x_d = cordic_x;
        y_d = cordic_y;
        valid_d[g_q] = 1'b1;
      end
`ifdef CORDIC_ARB_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = RESP;
        start_d = 1'b0;
        x_d = '0;
        y_d = '0;
        valid_d[g_q] = 1'b1;
        err_d = 1'b1;
      end else cnt_d = cnt_q + 1'b1;
`endif
      RESP: begin
        state_d = GAP;
        ptr_d = (g_q == IW'(N_REQ - 1)) ? '0 : g_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      g_q <= '0;
      ptr_q <= '0;
      angle_q <= '0;
      start_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      ack_q <= '0;
      valid_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      ptr_q <= ptr_d;
      angle_q <= angle_d;
      start_q <= start_d;
      x_q <= x_d;
      y_q <= y_d;
      ack_q <= ack_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  end
  assign req_ack = ack_q;
  assign rsp_valid = valid_q;
  assign rsp_x = x_q;
  assign rsp_y = y_q;
  assign busy = busy_q;
  assign cordic_start = start_q;
  assign cordic_angle = angle_q;
endmodule

// File: tb/tb_cordic_arbiter.sv
// tb_cordic_arbiter: directed bench with an 8-cycle cordic stub (out_x = angle, out_y = ~angle)
module tb_cordic_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_angle = '0;
  logic [N-1:0]   req_ack, rsp_valid;
  logic [W-1:0]   rsp_x, rsp_y, cordic_angle, cordic_x, cordic_y;
  logic           rsp_err, busy, cordic_start, cordic_done;
  logic [3:0]     stub_cnt = '0;
  logic           force_done = 1'b0, stub_off = 1'b0;
  cordic_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_angle(req_angle), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy),
    .cordic_start(cordic_start), .cordic_angle(cordic_angle), .cordic_done(cordic_done),
    .cordic_x(cordic_x), .cordic_y(cordic_y)
  );
  always @(posedge clk) stub_cnt <= cordic_start ? stub_cnt + 4'd1 : 4'd0;
  assign cordic_done = (cordic_start && stub_cnt == 4'd7 && !stub_off) || force_done;
  assign cordic_x = cordic_angle;
  assign cordic_y = ~cordic_angle;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int errs = 0, checks = 0, acks_seen = 0, rsps_seen = 0, ack_cyc, got_cyc;
  logic [N-1:0] got_v;
  logic [W-1:0] got_x, got_y;
  logic         got_err;
  logic [W-1:0] ang [N] = '{32'd0, 32'h8000_0000, 32'd715827883, 32'd1431655766};
  task automatic tick;
    @(negedge clk);
    if (req_ack != '0) acks_seen++;
    if (rsp_valid != '0) rsps_seen++;
    req = req & ~req_ack;
  endtask
  task automatic wait_ack(input string name);
    ack_cyc = -1;
    for (int i = 0; i < 40 && ack_cyc < 0; i++) begin
      tick();
      if (req_ack != '0) ack_cyc = cyc;
    end
    if (ack_cyc < 0) begin
      checks++; errs++;
      $display("FAIL %s: no req_ack within 40 cycles", name);
    end
  endtask
  task automatic wait_rsp(input string name);
    got_cyc = -1;
    got_v = '0;
    for (int i = 0; i < 40 && got_cyc < 0; i++) begin
      tick();
      if (rsp_valid != '0) begin
        got_cyc = cyc; got_v = rsp_valid; got_x = rsp_x; got_y = rsp_y; got_err = rsp_err;
      end
    end
    if (got_cyc < 0) begin
      checks++; errs++;
      $display("FAIL %s: no rsp_valid within 40 cycles", name);
    end
  endtask
  task automatic set_angles;
    for (int i = 0; i < N; i++) req_angle[i*W +: W] = ang[i];
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({req_ack, rsp_valid, rsp_err, busy} !== '0) begin
      errs++; $display("FAIL reset_ctrl: got %b expected 0", {req_ack, rsp_valid, rsp_err, busy});
    end
    checks++;
    if ({rsp_x, rsp_y} !== '0) begin
      errs++; $display("FAIL reset_rsp: got %h expected 0", {rsp_x, rsp_y});
    end
    checks++;
    if ({cordic_start, cordic_angle} !== '0) begin
      errs++; $display("FAIL reset_core: got %h expected 0", {cordic_start, cordic_angle});
    end
    reset = 1'b0;
  endtask
  task automatic test_single;
    int c0;
    set_angles();
    req = 4'b0001;
    tick();
    c0 = cyc;
    checks++;
    if ({req_ack, cordic_start, busy} !== 6'b0001_1_1) begin
      errs++; $display("FAIL single_grant: got %b expected 000111", {req_ack, cordic_start, busy});
    end
    checks++;
    if (cordic_angle !== 32'd0) begin
      errs++; $display("FAIL single_angle: got %h expected 0", cordic_angle);
    end
    tick();
    checks++;
    if (req_ack !== 4'b0000 || cordic_start !== 1'b1) begin
      errs++; $display("FAIL single_ack_pulse: got ack %b start %b expected 0000 1", req_ack, cordic_start);
    end
    wait_rsp("single_rsp");
    checks++;
    if (got_v !== 4'b0001 || got_err !== 1'b0) begin
      errs++; $display("FAIL single_valid: got %b err %b expected 0001 err 0", got_v, got_err);
    end
    checks++;
    if (got_x !== 32'h0 || got_y !== 32'hFFFF_FFFF) begin
      errs++; $display("FAIL single_data: got %h/%h expected 00000000/ffffffff", got_x, got_y);
    end
    checks++;
    if (got_cyc - c0 !== 8) begin
      errs++; $display("FAIL single_latency: got %0d expected 8", got_cyc - c0);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b1 || cordic_start !== 1'b0) begin
      errs++; $display("FAIL single_gap: got valid %b busy %b start %b expected 0000 1 0", rsp_valid, busy, cordic_start);
    end
    checks++;
    if (rsp_x !== 32'h0 || rsp_y !== 32'hFFFF_FFFF) begin
      errs++; $display("FAIL single_hold: got %h/%h expected 00000000/ffffffff", rsp_x, rsp_y);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL single_busy_fall: got %b expected 0", busy);
    end
  endtask
  task automatic test_all_four;
    int prev;
    logic [N-1:0] exp_v;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111;
    prev = 0;
    for (int k = 0; k < N; k++) begin
      exp_v = 4'b0001 << k;
      wait_ack("all4_ack");
      checks++;
      if (req_ack !== exp_v) begin
        errs++; $display("FAIL all4_order[%0d]: got %b expected %b", k, req_ack, exp_v);
      end
      if (k > 0) begin
        checks++;
        if (ack_cyc - prev !== 11) begin
          errs++; $display("FAIL all4_spacing[%0d]: got %0d expected 11", k, ack_cyc - prev);
        end
      end
      prev = ack_cyc;
      wait_rsp("all4_rsp");
      checks++;
      if (got_v !== exp_v || got_err !== 1'b0) begin
        errs++; $display("FAIL all4_valid[%0d]: got %b err %b expected %b err 0", k, got_v, got_err, exp_v);
      end
      checks++;
      if (got_x !== ang[k] || got_y !== ~ang[k]) begin
        errs++; $display("FAIL all4_data[%0d]: got %h/%h expected %h/%h", k, got_x, got_y, ang[k], ~ang[k]);
      end
    end
  endtask
  task automatic test_round_robin;
    req = 4'b0010;
    wait_ack("rr_first_ack");
    checks++;
    if (req_ack !== 4'b0010) begin
      errs++; $display("FAIL rr_first: got %b expected 0010", req_ack);
    end
    wait_rsp("rr_first_rsp");
    req = 4'b1001;
    wait_ack("rr_a_ack");
    checks++;
    if (req_ack !== 4'b1000) begin
      errs++; $display("FAIL rr_three_first: got %b expected 1000", req_ack);
    end
    wait_rsp("rr_a_rsp");
    checks++;
    if (got_v !== 4'b1000 || got_x !== ang[3]) begin
      errs++; $display("FAIL rr_three_rsp: got %b %h expected 1000 %h", got_v, got_x, ang[3]);
    end
    wait_ack("rr_b_ack");
    checks++;
    if (req_ack !== 4'b0001) begin
      errs++; $display("FAIL rr_zero_second: got %b expected 0001", req_ack);
    end
    wait_rsp("rr_b_rsp");
  endtask
  task automatic test_late_req;
    req = 4'b0001;
    wait_ack("late_ack0");
    tick(); tick(); tick();
    req[1] = 1'b1;
    acks_seen = 0;
    wait_rsp("late_rsp0");
    checks++;
    if (got_v !== 4'b0001 || acks_seen !== 0) begin
      errs++; $display("FAIL late_no_pregrant: got valid %b acks %0d expected 0001 0", got_v, acks_seen);
    end
    tick(); tick();
    checks++;
    if (acks_seen !== 0 || req_ack !== 4'b0000) begin
      errs++; $display("FAIL late_wait_idle: got acks %0d ack %b expected 0 0000", acks_seen, req_ack);
    end
    tick();
    checks++;
    if (req_ack !== 4'b0010) begin
      errs++; $display("FAIL late_grant_at_idle: got %b expected 0010", req_ack);
    end
    wait_rsp("late_rsp1");
    checks++;
    if (got_v !== 4'b0010 || got_x !== ang[1]) begin
      errs++; $display("FAIL late_rsp1: got %b %h expected 0010 %h", got_v, got_x, ang[1]);
    end
  endtask
  task automatic test_reset_mid;
    req = 4'b0001;
    wait_ack("rmid_ack");
    tick(); tick(); tick();
    reset = 1'b1;
    rsps_seen = 0;
    tick();
    checks++;
    if ({cordic_start, busy, req_ack, rsp_valid} !== '0 || cordic_angle !== '0) begin
      errs++; $display("FAIL rmid_outputs: got start %b busy %b ack %b valid %b angle %h expected all 0", cordic_start, busy, req_ack, rsp_valid, cordic_angle);
    end
    reset = 1'b0;
    force_done = 1'b1;
    tick();
    force_done = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if (rsps_seen !== 0 || busy !== 1'b0) begin
      errs++; $display("FAIL rmid_discard: got rsps %0d busy %b expected 0 0", rsps_seen, busy);
    end
    req = 4'b1001;
    wait_ack("rmid_ptr_ack");
    checks++;
    if (req_ack !== 4'b0001) begin
      errs++; $display("FAIL rmid_ptr_zero: got %b expected 0001", req_ack);
    end
    wait_rsp("rmid_rsp0");
    wait_ack("rmid_ack3");
    checks++;
    if (req_ack !== 4'b1000) begin
      errs++; $display("FAIL rmid_next: got %b expected 1000", req_ack);
    end
    wait_rsp("rmid_rsp3");
  endtask
`ifdef CORDIC_ARB_TIMEOUT_EN
  task automatic test_timeout;
    int c0;
    stub_off = 1'b1;
    req = 4'b0001;
    wait_ack("to_ack");
    c0 = ack_cyc;
    wait_rsp("to_rsp");
    checks++;
    if (got_v !== 4'b0001 || got_err !== 1'b1 || got_x !== '0 || got_y !== '0) begin
      errs++; $display("FAIL to_err_rsp: got %b err %b %h/%h expected 0001 err 1 0/0", got_v, got_err, got_x, got_y);
    end
    checks++;
    if (got_cyc - c0 !== 16 || cordic_start !== 1'b0) begin
      errs++; $display("FAIL to_start_len: got %0d start %b expected 16 0", got_cyc - c0, cordic_start);
    end
    stub_off = 1'b0;
    req = 4'b0010;
    wait_ack("to_next_ack");
    wait_rsp("to_next_rsp");
    checks++;
    if (got_v !== 4'b0010 || got_err !== 1'b0 || got_x !== ang[1]) begin
      errs++; $display("FAIL to_next: got %b err %b %h expected 0010 err 0 %h", got_v, got_err, got_x, ang[1]);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_round_robin();
    test_late_req();
    test_reset_mid();
`ifdef CORDIC_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
